usb_tx_packet_buffer: RTL and testbench

//  Upstream feeder for the USB full-speed packet encoder. Endpoint logic writes payload bytes

---
 rtl/usb_tx_packet_buffer_pkg.sv | 24 ++
 rtl/usb_tx_packet_buffer_if.sv | 33 +++
 rtl/usb_tx_byte_ram.sv | 23 ++
 rtl/usb_tx_packet_buffer.sv | 112 +++++++++++
 tb/tb_usb_tx_packet_buffer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_packet_buffer_pkg.sv
// Shared definitions for the USB TX packet buffer: PID nibbles and FSM states.
package usb_tx_packet_buffer_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_DATA2 = 4'b0111;
    localparam logic [3:0] PID_MDATA = 4'b1111;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_NYET  = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

endpackage

// File: rtl/usb_tx_packet_buffer_if.sv
// Endpoint-side write/send signals and encoder-side byte handshake of the TX buffer.
interface usb_tx_packet_buffer_if #(
    parameter int unsigned MAX_BYTES = 64
);
    localparam int unsigned CW = $clog2(MAX_BYTES) + 1;

    logic [7:0]    wr_data;
    logic          wr_en;
    logic          wr_full;
    logic          buf_clear;
    logic [CW-1:0] byte_count;
    logic          send_req;
    logic [3:0]    send_pid;
    logic          busy;
    logic          send_done;
    logic          enc_reset;
    logic [3:0]    enc_pid;
    logic [7:0]    enc_byte;
    logic          enc_last_byte;
    logic          enc_byte_ack;
    logic          enc_done;

    modport slave (
        input  wr_data, wr_en, buf_clear, send_req, send_pid, enc_byte_ack, enc_done,
        output wr_full, byte_count, busy, send_done, enc_reset, enc_pid, enc_byte, enc_last_byte
    );

    modport master (
        output wr_data, wr_en, buf_clear, send_req, send_pid, enc_byte_ack, enc_done,
        input  wr_full, byte_count, busy, send_done, enc_reset, enc_pid, enc_byte, enc_last_byte
    );

endinterface

// File: rtl/usb_tx_byte_ram.sv
// Payload storage: single write port, asynchronous read port, contents not reset.
module usb_tx_byte_ram #(
    parameter int unsigned MAX_BYTES = 64
) (
    input  logic                         clk48,
    input  logic                         we,
    input  logic [$clog2(MAX_BYTES)-1:0] waddr,
    input  logic [7:0]                   wdata,
    input  logic [$clog2(MAX_BYTES)-1:0] raddr,
    output logic [7:0]                   rdata
);

    logic [7:0] mem [MAX_BYTES];

    always_ff @(posedge clk48) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/usb_tx_packet_buffer.sv
// Feeds the USB FS packet encoder from a local payload buffer; payload survives a send
// so a NAKed DATA packet can be replayed with a fresh send_req.
module usb_tx_packet_buffer
    import usb_tx_packet_buffer_pkg::*;
#(
    parameter int unsigned MAX_BYTES  = 64,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                   clk48,
    input  logic                   reset,
    usb_tx_packet_buffer_if.slave  bus
);

    localparam int unsigned AW = $clog2(MAX_BYTES);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_BYTES);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    pid_q, pid_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          ram_we;
    logic          full;

    assign full = (count_q == FULL_CNT);

    always_ff @(posedge clk48) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            pid_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            pid_q    <= pid_d;
            gap_q    <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        pid_d    = pid_q;
        gap_d    = gap_q;
        ram_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // clear beats write; a same-cycle send_req drops the write
                if (bus.buf_clear) begin
                    count_d = '0;
                end else if (bus.wr_en && !full && !bus.send_req) begin
                    ram_we  = 1'b1;
                    count_d = count_q + CW'(1);
                end
                if (bus.send_req) begin
                    pid_d    = bus.send_pid;
                    rd_ptr_d = '0;
                    state_d  = ST_ARM;
                end
            end
            ST_ARM: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (bus.enc_byte_ack && (rd_ptr_q != count_q)) begin
                    rd_ptr_d = rd_ptr_q + CW'(1);
                end
                if (bus.enc_done) begin
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    usb_tx_byte_ram #(
        .MAX_BYTES(MAX_BYTES)
    ) u_ram (
        .clk48 (clk48),
        .we    (ram_we),
        .waddr (count_q[AW-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (bus.enc_byte)
    );

    assign bus.wr_full       = full;
    assign bus.byte_count    = count_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.send_done     = (state_q == ST_GAP) && (gap_q == '0);
    assign bus.enc_reset     = (state_q != ST_SEND);
    assign bus.enc_pid       = pid_q;
    assign bus.enc_last_byte = (rd_ptr_q == count_q);

endmodule

// File: tb/tb_usb_tx_packet_buffer.sv
// Randomized scoreboard bench for usb_tx_packet_buffer against a queue-based payload model.
module tb_usb_tx_packet_buffer;
    import usb_tx_packet_buffer_pkg::*;

    localparam int unsigned MAXB = 64;
    localparam int unsigned GAP  = 16;

    logic clk48 = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [7:0] mdl[$];
    logic [7:0] exp_q[$];

    usb_tx_packet_buffer_if #(.MAX_BYTES(MAXB)) bus ();

    usb_tx_packet_buffer #(
        .MAX_BYTES (MAXB),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk48(clk48),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk48 = ~clk48;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    // Scoreboard monitor: every ack the encoder side issues must match the next queued byte.
    always @(negedge clk48) begin
        if (bus.enc_byte_ack) begin
            if (exp_q.size() == 0) begin
                chk("ack_without_expected_byte", 32'd1, 32'd0);
            end else begin
                chk("enc_byte", {24'd0, bus.enc_byte}, {24'd0, exp_q.pop_front()});
                chk("last_byte_during_ack", {31'd0, bus.enc_last_byte}, 32'd0);
            end
        end
    end

    task automatic do_write(input logic [7:0] d);
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
        if (mdl.size() < MAXB) mdl.push_back(d);
        @(negedge clk48);
        chk("byte_count_after_write", 32'(bus.byte_count), 32'(mdl.size()));
        chk("wr_full", {31'd0, bus.wr_full}, {31'd0, (mdl.size() == MAXB)});
    endtask

    task automatic do_clear();
        tick();
        bus.buf_clear = 1'b1;
        bus.wr_en     = 1'($urandom_range(0, 1));
        bus.wr_data   = 8'($urandom);
        tick();
        bus.buf_clear = 1'b0;
        bus.wr_en     = 1'b0;
        mdl.delete();
        @(negedge clk48);
        chk("byte_count_after_clear", 32'(bus.byte_count), 32'd0);
        chk("wr_full_after_clear", {31'd0, bus.wr_full}, 32'd0);
    endtask

    task automatic do_send(input logic [3:0] pid, input bit guard, input bit abort);
        int unsigned n;
        int unsigned k;
        n = mdl.size();
        foreach (mdl[i]) exp_q.push_back(mdl[i]);
        tick();
        bus.send_req = 1'b1;
        bus.send_pid = pid;
        bus.wr_en    = 1'($urandom_range(0, 1));
        bus.wr_data  = 8'($urandom);
        tick();
        bus.send_req = 1'b0;
        bus.wr_en    = 1'b0;
        @(negedge clk48);
        chk("arm_busy", {31'd0, bus.busy}, 32'd1);
        chk("arm_enc_reset", {31'd0, bus.enc_reset}, 32'd1);
        chk("arm_enc_pid", {28'd0, bus.enc_pid}, {28'd0, pid});
        chk("arm_last_byte", {31'd0, bus.enc_last_byte}, {31'd0, (n == 0)});
        chk("arm_count_write_dropped", 32'(bus.byte_count), 32'(n));
        tick();
        @(negedge clk48);
        chk("send_enc_reset", {31'd0, bus.enc_reset}, 32'd0);
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            repeat ($urandom_range(0, 3)) tick();
            bus.enc_byte_ack = 1'b1;
            tick();
            bus.enc_byte_ack = 1'b0;
            if (abort) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                mdl.delete();
                exp_q.delete();
                @(negedge clk48);
                chk("abort_busy", {31'd0, bus.busy}, 32'd0);
                chk("abort_enc_reset", {31'd0, bus.enc_reset}, 32'd1);
                chk("abort_byte_count", 32'(bus.byte_count), 32'd0);
                for (int c = 0; c < 20; c++) begin
                    chk("abort_no_send_done", {31'd0, bus.send_done}, 32'd0);
                    @(negedge clk48);
                end
                return;
            end
        end
        @(negedge clk48);
        chk("last_byte_after_acks", {31'd0, bus.enc_last_byte}, 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        if (guard) begin
            tick();
            bus.wr_en     = 1'b1;
            bus.buf_clear = 1'b1;
            bus.send_req  = 1'b1;
            bus.wr_data   = 8'($urandom);
            tick();
            bus.wr_en     = 1'b0;
            bus.buf_clear = 1'b0;
            bus.send_req  = 1'b0;
            @(negedge clk48);
            chk("guard_byte_count", 32'(bus.byte_count), 32'(n));
            chk("guard_busy", {31'd0, bus.busy}, 32'd1);
            chk("guard_still_send", {31'd0, bus.enc_reset}, 32'd0);
            chk("guard_last_byte", {31'd0, bus.enc_last_byte}, 32'd1);
        end
        tick();
        bus.enc_done = 1'b1;
        tick();
        bus.enc_done = 1'b0;
        k = 1;
        forever begin
            @(negedge clk48);
            chk("gap_enc_reset", {31'd0, bus.enc_reset}, 32'd1);
            if (bus.send_done || k >= 40) break;
            k++;
        end
        chk("gap_length_to_send_done", k, GAP);
        @(negedge clk48);
        chk("idle_after_gap", {31'd0, bus.busy}, 32'd0);
        chk("send_done_one_cycle", {31'd0, bus.send_done}, 32'd0);
        chk("count_kept_after_send", 32'(bus.byte_count), 32'(n));
    endtask

    initial begin
        bus.wr_data      = '0;
        bus.wr_en        = 1'b0;
        bus.buf_clear    = 1'b0;
        bus.send_req     = 1'b0;
        bus.send_pid     = '0;
        bus.enc_byte_ack = 1'b0;
        bus.enc_done     = 1'b0;
        repeat (3) tick();
        @(negedge clk48);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_send_done", {31'd0, bus.send_done}, 32'd0);
        chk("rst_enc_reset", {31'd0, bus.enc_reset}, 32'd1);
        chk("rst_last_byte", {31'd0, bus.enc_last_byte}, 32'd1);
        chk("rst_wr_full", {31'd0, bus.wr_full}, 32'd0);
        chk("rst_byte_count", 32'(bus.byte_count), 32'd0);
        chk("rst_enc_pid", {28'd0, bus.enc_pid}, 32'd0);
        reset = 1'b0;

        do_send(PID_ACK, 1'b0, 1'b0);
        do_write(8'h80);
        do_write(8'h06);
        do_write(8'h00);
        do_send(PID_DATA0, 1'b0, 1'b0);
        do_send(PID_DATA0, 1'b0, 1'b0);
        do_clear();
        do_send(PID_DATA1, 1'b0, 1'b0);
        for (int i = 0; i < 65; i++) do_write(8'($urandom));
        do_send(PID_DATA1, 1'b0, 1'b0);
        do_clear();
        for (int i = 0; i < 5; i++) do_write(8'($urandom));
        do_send(PID_DATA0, 1'b1, 1'b0);
        do_send(PID_DATA1, 1'b0, 1'b1);

        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 2) == 0) do_clear();
            repeat ($urandom_range(0, 20)) do_write(8'($urandom));
            do_send(4'($urandom), 1'($urandom_range(0, 1)),
                    (mdl.size() > 0) && ($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
